// File: rtl/rsa_pkg.sv
// Shared types and sizing helpers for the RSA datapath blocks.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 8;

  // Iteration counter must index 2*WIDTH doubling steps.
  localparam int unsigned RSA_CNT_W = $clog2(2 * RSA_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/rsa_mod_double.sv
// Modular doubling: (r, m) -> 2r mod m, valid while r < m.
module rsa_mod_double
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] dbl_c
);

  logic [WIDTH:0]   twice;
  logic [WIDTH-1:0] twice_sub;
  logic             ge;

  // 2r < 2m, so a single conditional subtract restores r < m; the difference fits in WIDTH bits.
  always_comb begin
    twice     = {r, 1'b0};
    ge        = (twice >= {1'b0, m});
    twice_sub = twice[WIDTH-1:0] - m;
    dbl_c     = ge ? twice_sub : twice[WIDTH-1:0];
  end

endmodule

// File: rtl/rsa_mont_const_gen.sv
// Computes the Montgomery constant R^2 mod M (R = 2^WIDTH) by 2*WIDTH
// bit-serial double-and-reduce steps behind a start/busy/done handshake.
module rsa_mont_const_gen
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mod_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] const_out
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d, err_d;
  logic [WIDTH-1:0] const_d;
  logic [WIDTH-1:0] dbl_c;
  logic             mod_valid_c;

  rsa_mod_double #(
    .WIDTH (WIDTH)
  ) u_mod_double (
    .r     (r_q),
    .m     (m_q),
    .dbl_c (dbl_c)
  );

  assign mod_valid_c = (mod_in != '0) && mod_in[0];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      const_out <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      const_out <= const_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err;
    const_d = const_out;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mod_valid_c) begin
            m_d     = mod_in;
            // R^0 mod M is 1, except when M is 1.
            r_d     = (mod_in == WIDTH'(1)) ? '0 : WIDTH'(1);
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = RUN;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        r_d   = dbl_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          const_d = dbl_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_rsa_mont_const_gen.sv
// Directed and randomised checks of the R^2 mod M generator (WIDTH = 8).
module tb_rsa_mont_const_gen;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] mod_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] const_out;

  int tests;
  int fails;

  rsa_mont_const_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mod_in    (mod_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .const_out (const_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] m);
    start  = 1'b1;
    mod_in = m;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Wait for done (bounded) and check latency, busy occupancy and results.
  task automatic wait_done(input string tag, input int n0, input int exp_lat,
                           input logic [W-1:0] exp_const, input logic exp_err);
    int n;
    int busy_cycles;
    n = n0;
    busy_cycles = n0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'(1));
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    check({tag, "_const"}, 32'(const_out), 32'(exp_const));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] exp_c;
    int seen_done;

    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mod_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_const", 32'(const_out), 32'(0));

    // Basic request.
    launch(8'hF7);
    check("f7_busy_after_accept", 32'(busy), 32'(1));
    wait_done("f7", 0, 16, 8'h51, 1'b0);
    @(posedge clk); #1;
    check("f7_done_drops", 32'(done), 32'(0));
    check("f7_const_held", 32'(const_out), 32'(8'h51));

    // Back-to-back: each start raised during the previous done cycle.
    launch(8'hFF);
    wait_done("ff", 0, 16, 8'h01, 1'b0);
    launch(8'h0D);
    check("0d_done_dropped", 32'(done), 32'(0));
    wait_done("0d", 0, 16, 8'h03, 1'b0);
    launch(8'h81);
    wait_done("81", 0, 16, 8'h04, 1'b0);
    @(posedge clk); #1;

    // M = 1 and invalid moduli.
    launch(8'h01);
    wait_done("m1", 0, 16, 8'h00, 1'b0);
    @(posedge clk); #1;
    launch(8'hF7);
    wait_done("f7b", 0, 16, 8'h51, 1'b0);
    @(posedge clk); #1;
    launch(8'h00);
    check("m0_busy", 32'(busy), 32'(0));
    wait_done("m0", 0, 0, 8'h51, 1'b1);
    @(posedge clk); #1;
    check("m0_done_drops", 32'(done), 32'(0));
    check("m0_err_held", 32'(err), 32'(1));
    launch(8'h42);
    wait_done("m42", 0, 0, 8'h51, 1'b1);
    @(posedge clk); #1;

    // Start re-pulse with new mod_in mid-run is ignored.
    launch(8'hF7);
    check("ign_err_cleared", 32'(err), 32'(0));
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    mod_in = 8'h03;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_done("ign", 5, 16, 8'h51, 1'b0);
    @(posedge clk); #1;

    // Reset mid-run aborts without a done pulse.
    launch(8'hF7);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_const", 32'(const_out), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen_done++;
      @(posedge clk); #1;
    end
    check("abort_quiet", 32'(seen_done), 32'(0));
    launch(8'h0D);
    wait_done("post_abort", 0, 16, 8'h03, 1'b0);
    @(posedge clk); #1;

    // Randomised odd moduli against 65536 mod M.
    for (int i = 0; i < 500; i++) begin
      m     = W'($urandom_range(0, 127) * 2 + 1);
      exp_c = W'(65536 % int'(m));
      launch(m);
      wait_done("rand", 0, 16, exp_c, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsa_mont_const_gen.md
# rsa_mont_const_gen

Precomputes the Montgomery constant R² mod M, with R = 2^WIDTH, from the RSA modulus M. It sits directly upstream of the RSA core and produces the value the core consumes on its `Const` input. This removes the need for software to compute the constant before each encryption. The block uses a bit-serial double-and-reduce loop of 2·WIDTH iterations with a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand width in bits; must match the RSA core's WIDTH.

- `clk`  in  1  project clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `mod_in`  in  WIDTH  modulus M; latched on the accepted start edge.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse at completion, including error completion.
- `err`  out  1  result of the last request: 1 = M invalid (zero or even); held until next accepted start.
- `const_out`  out  WIDTH  R² mod M; held until next successful completion.

## Operation
- States: IDLE, RUN.
- **IDLE + start, M valid** (M odd, nonzero):
  - latch M; r ← (M==1) ? 0 : 1; cnt ← 0; err ← 0; go to RUN.
- **IDLE + start, M invalid** (M==0 or M[0]==0):
  - err ← 1; done ← 1 next cycle; const_out unchanged; stay IDLE.
- **RUN, each edge**: r ← 2r; if 2r ≥ M then r ← 2r − M.
  - 2r uses a WIDTH+1-bit datapath; one conditional subtract suffices because the invariant r < M holds.
  - cnt ← cnt + 1.
- **RUN, cnt == 2·WIDTH−1**: const_out ← reduced value; done ← 1; go to IDLE.
- start while RUN: ignored, no queuing.
- mod_in changes during RUN: no effect (latched copy used).
- start held high continuously: a new request is accepted on the first IDLE edge after done.
- cnt width: clog2(2·WIDTH).

## Timing
- Reset values: state IDLE; busy 0, done 0, err 0, const_out 0, r 0, cnt 0.
- `rst` wins over every other input in the same cycle.
- `rst` asserted mid-RUN aborts the operation: no done pulse, const_out returns to 0.
- Let start be accepted on edge k:
  - busy is high from after edge k through edge k+2·WIDTH, i.e. 2·WIDTH cycles.
  - const_out updates and done goes high after edge k+2·WIDTH; done drops on the next edge.
  - The earliest next accept is edge k+2·WIDTH+1. With WIDTH=8, latency is 16 cycles.
- Invalid M: done and err go high after edge k; busy never asserts.
- busy is a registered decode of state == RUN. done is registered.
- Downstream capture: sample const_out on the done cycle; const_out and err are stable thereafter.

## Structure
- Shared package `rsa_pkg`:
  - state enum (IDLE, RUN);
  - `RSA_WIDTH` default (8);
  - helper localparam for cnt width.
- One combinational sub-module, `rsa_mod_double`.
  - Function: (r, M) → (2r mod M) assuming r < M.
  - It is reusable by the RSA core's Montgomery reduction path.
- FSM, counter and output registers live in the top.

## Test plan
- M=0xF7 (247), pulse start → busy 16 cycles, done pulse, const_out=0x51 (65536 mod 247 = 81), err=0.
- Back-to-back requests:
  - M=0xFF → const_out=0x01.
  - Then immediately M=0x0D → const_out=0x03.
  - Then M=0x81 → const_out=0x04.
  - Each done occurs exactly 16 cycles after its accept.
- M=0x01 → const_out=0x00, err=0; M=0x00 and M=0x42 → err=1, done 1 cycle after start, busy never high, const_out retains previous value.
- Start re-pulsed and mod_in changed to 0x03 at cycle 5 of a run with M=0xF7 → ignored; result still 0x51 at cycle 16.
- rst asserted at cycle 8 of a run → next cycle: busy 0, const_out 0, no done; a fresh start with M=0x0D then yields 0x03.
- Randomised odd M (1..255) vs reference model 65536 mod M, ≥500 requests, check latency and value each time.
